// File: rtl/rx_elastic_fifo_pkg.sv
// Shared types for the rx elastic buffer: drop counter width, type and saturating increment.
// No storage, no latency, no flow control of its own.
package rx_elastic_fifo_pkg;
  localparam int DROP_CNT_W = 16;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == '1) ? v : v + drop_cnt_t'(1);
  endfunction
endpackage

// File: rtl/rx_elastic_fifo_ram_sdp.sv
// Simple-dual-port distributed storage: synchronous write, asynchronous read, contents not reset.
// Write visible on read port one edge after the write; no flow control.
module fifo_ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clkIn,
  input  logic                  wrEnIn,
  input  logic [AW-1:0]         wrAddrIn,
  input  logic [DATA_WIDTH-1:0] wrDataIn,
  input  logic [AW-1:0]         rdAddrIn,
  output logic [DATA_WIDTH-1:0] rdDataOut
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clkIn) begin
    if (wrEnIn) mem[wrAddrIn] <= wrDataIn;
  end

  assign rdDataOut = mem[rdAddrIn];
endmodule

// File: rtl/rx_elastic_fifo.sv
// FWFT elastic buffer with valid/ready read side, 1-cycle write-to-valid (0 with RX_ELASTIC_FIFO_BYPASS_EN).
// Writer is never backpressured: writes while full without a pop are dropped and counted.
module rx_elastic_fifo
  import rx_elastic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clkIn,
  input  logic                     rstNIn,
  input  logic                     wrEnIn,
  input  logic [DATA_WIDTH-1:0]    wrDataIn,
  input  logic                     rdReadyIn,
  output logic [DATA_WIDTH-1:0]    rdDataOut,
  output logic                     rdValidOut,
  output logic [$clog2(DEPTH):0]   levelOut,
  output logic                     fullOut,
  output logic                     almostFullOut,
  input  logic                     clrOverflowIn,
  output logic                     overflowOut,
  output logic [DROP_CNT_W-1:0]    dropCntOut
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]         wrPtr, rdPtr;
  logic [LW-1:0]         level, levelNext;
  logic                  validReg;
  logic [DATA_WIDTH-1:0] dataReg, headNext, ramRdData;
  logic                  fullReg, afullReg, ovfReg;
  drop_cnt_t             dropCnt;
  logic                  pop, accept, drop, isFull, isEmpty;

  assign isFull  = (level == LW'(DEPTH));
  assign isEmpty = (level == '0);

`ifdef RX_ELASTIC_FIFO_BYPASS_EN
  assign rdValidOut = validReg | (isEmpty & wrEnIn);
  assign rdDataOut  = (isEmpty & wrEnIn) ? wrDataIn : dataReg;
`else
  assign rdValidOut = validReg;
  assign rdDataOut  = dataReg;
`endif

  assign pop    = rdValidOut & rdReadyIn;
  assign accept = wrEnIn & (~isFull | pop);
  assign drop   = wrEnIn & isFull & ~pop;

  // Storage holds every queued word including the head; dataReg mirrors the head.
  // A bypass word consumed at level 0 is written and both pointers step past it.
  fifo_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clkIn     (clkIn),
    .wrEnIn    (accept),
    .wrAddrIn  (wrPtr),
    .wrDataIn  (wrDataIn),
    .rdAddrIn  (rdPtr + AW'(1)),
    .rdDataOut (ramRdData)
  );

  always_comb begin
    levelNext = level;
    if (accept && !pop)      levelNext = level + LW'(1);
    else if (pop && !accept) levelNext = level - LW'(1);
  end

  // After a pop the new head is the next stored word, or the incoming word if only one was held.
  always_comb begin
    headNext = dataReg;
    if (pop) begin
      if (level >= LW'(2)) headNext = ramRdData;
      else                 headNext = wrDataIn;
    end else if (isEmpty && accept) begin
      headNext = wrDataIn;
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      validReg <= 1'b0;
      dataReg  <= '0;
      fullReg  <= 1'b0;
      afullReg <= 1'b0;
      ovfReg   <= 1'b0;
      dropCnt  <= '0;
    end else begin
      if (accept) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      level    <= levelNext;
      validReg <= (levelNext != '0);
      dataReg  <= headNext;
      fullReg  <= (levelNext == LW'(DEPTH));
      afullReg <= (levelNext >= LW'(AFULL_THRESH));
      // Clear wins over a same-cycle drop, which then becomes the first counted drop.
      if (clrOverflowIn) begin
        ovfReg  <= drop;
        dropCnt <= drop ? drop_cnt_t'(1) : '0;
      end else if (drop) begin
        ovfReg  <= 1'b1;
        dropCnt <= sat_inc(dropCnt);
      end
    end
  end

  assign levelOut      = level;
  assign fullOut       = fullReg;
  assign almostFullOut = afullReg;
  assign overflowOut   = ovfReg;
  assign dropCntOut    = dropCnt;
endmodule

// File: doc/rx_elastic_fifo.md
# rx_elastic_fifo

Single-clock, parametrised first-word-fall-through elastic buffer with a valid/ready read handshake. It sits in the 250 MHz domain directly behind the 125→250 MHz clock-domain crossing and absorbs bursty byte traffic ahead of the parser. It adds configurable width and depth, occupancy and almost-full reporting, and overflow accounting: a sticky flag plus a saturating drop counter. An optional low-latency bypass path is available.

## Interface
- DATA_WIDTH, 8 — word width in bits.
- DEPTH, 16 — storage capacity in words; must be a power of two, ≥4.
- AFULL_THRESH, DEPTH-2 — `almostFullOut` asserts when level ≥ this value; legal range is 1..DEPTH.
- clkIn  in  1 — single clock; every register in the block uses it.
- rstNIn  in  1 — reset, asynchronous, active-low.
- wrEnIn  in  1 — write strobe; there is no backpressure to the writer.
- wrDataIn  in  DATA_WIDTH — write data.
- rdReadyIn  in  1 — consumer ready.
- rdDataOut  out  DATA_WIDTH — head-of-queue word.
- rdValidOut  out  1 — `rdDataOut` is valid.
- levelOut  out  $clog2(DEPTH)+1 — words held, 0..DEPTH.
- fullOut  out  1 — level == DEPTH.
- almostFullOut  out  1 — level ≥ AFULL_THRESH.
- clrOverflowIn  in  1 — clears `overflowOut` and `dropCntOut`.
- overflowOut  out  1 — sticky: at least one write was dropped.
- dropCntOut  out  16 — count of dropped writes, saturating at 0xFFFF.

## Operation
- Reset is asynchronous, active-low. While `rstNIn`=0, every output is 0: `rdDataOut`, `rdValidOut`, `levelOut`, `fullOut`, `almostFullOut`, `overflowOut`, `dropCntOut`. Pointers are also 0. Deassertion is synchronised upstream.
- A pop occurs on `rdValidOut & rdReadyIn`. `rdReadyIn` has no effect while `rdValidOut`=0.
- A write is accepted when `wrEnIn` & (level<DEPTH | pop). Write-while-full with a simultaneous pop is therefore accepted, and the level stays at DEPTH.
- A write is dropped when `wrEnIn` & full & no pop:
  - the data is discarded and the level is unchanged;
  - `overflowOut` sets to 1;
  - `dropCntOut` increments by 1 and holds at 0xFFFF.
- Level update, in one cycle: +1 on accept without pop, −1 on pop without accept, unchanged on both or neither.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Level is kept in its own counter and is never derived from the pointers.
- `rdDataOut` holds its value while `rdValidOut`=1 and `rdReadyIn`=0. Data ordering is strict FIFO.
- `clrOverflowIn`:
  - clears both `overflowOut` and `dropCntOut` on the next edge;
  - if a drop happens in the same cycle, the clear wins and the drop is reported in the following cycle's state: flag=1, count=1.
- `fullOut`, `almostFullOut` and `levelOut` are registered and reflect state after the edge.
- Data is never modified. There is no error-correction and no reordering.

## Timing
- Write-to-valid latency, FIFO empty, bypass off: write at edge N → `rdValidOut`=1 after edge N+1, i.e. one cycle.
- Back-to-back pops sustain one word per cycle while the level is >0.
- Simultaneous write and pop at level 1: the output stays valid continuously with no bubble.
- Status flags update on the same edge as the level.

## Configuration
- `RX_ELASTIC_FIFO_BYPASS_EN` defined:
  - when level==0 and `wrEnIn`=1, `rdValidOut`=1 and `rdDataOut`=`wrDataIn` combinationally in the same cycle;
  - if `rdReadyIn`=1 in that cycle, the word is consumed, not stored, and the level stays 0;
  - otherwise it is stored normally and presented from storage the next cycle.
  - This creates a combinational path from `wrDataIn`/`wrEnIn` to the outputs; latency is 0 cycles.
- Not defined: all outputs are registered and the minimum latency is 1 cycle as above.

## Structure
- Shared package `pkg` holds:
  - `DROP_CNT_W = 16`;
  - typedef `drop_cnt_t` of that width;
  - a `sat_inc` function for the saturating counter.
- One sub-module, `fifo_ram_sdp`: simple-dual-port distributed storage, DATA_WIDTH × DEPTH. It has a synchronous write and an asynchronous read by address, and no reset on the contents.
- The top level owns the pointers, level counter, output register, overflow logic and bypass mux.

## Test plan
- Reset mid-operation: fill to level 5, pull `rstNIn` low between edges → all outputs 0 immediately. After release, write 0xA5 → `rdValidOut`=1 with 0xA5 one cycle later.
- Fill/drain with DEPTH=16, `rdReadyIn`=0: write 0x00..0x0F → level 16, `fullOut`=1, `almostFullOut`=1 from level 14. Then `rdReadyIn`=1 → reads 0x00..0x0F in order, with `rdValidOut` continuous for 16 cycles.
- Overflow: full, `rdReadyIn`=0, write 3 more → `overflowOut`=1, `dropCntOut`=3, level 16, and the head is still 0x00. Pulse `clrOverflowIn` → both 0.
- Simultaneous at full: write 0x55 with a pop in the same cycle → accepted, no drop, level 16, and 0x55 is read last.
- Wrap-around: 40 words streamed continuously with `rdReadyIn` toggling at random → output sequence equals input sequence and the level never exceeds 16.
- Bypass, with the macro defined: empty, write 0x3C with `rdReadyIn`=1 → `rdValidOut`=1, data 0x3C in the same cycle, level stays 0. Repeat with `rdReadyIn`=0 → level 1, and 0x3C is still presented next cycle.
